score_arbiter: RTL and testbench

//  Parametrised end-of-game scorer: tallies cell ownership on an N-cell board shared by P players
//  and reports the winner, the tie status and the winning count.

---
 rtl/score_pkg.sv | 32 +++
 rtl/score_counter_bank.sv | 49 ++++
 rtl/score_arbiter.sv | 208 ++++++++++++++++++++
 tb/tb_score_arbiter.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/score_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : score_pkg
//  Purpose  : Shared FSM state encoding, owner-code constant and width helpers
//             for the score_arbiter end-of-game scorer.
//  Revision : 1.0 - initial release
// ============================================================================
package score_pkg;

  // Scan sequencer states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_CMP  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Owner code of an unclaimed cell
  localparam int OWNER_EMPTY = 0;

  // Owner-code width: must hold 0 (empty) through num_players
  function automatic int pid_width(input int num_players);
    return $clog2(num_players + 1);
  endfunction

  // Per-player count width: must hold 0 through num_cells
  function automatic int cnt_width(input int num_cells);
    return $clog2(num_cells + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/score_counter_bank.sv
`default_nettype none
// ============================================================================
//  Module   : score_counter_bank
//  Purpose  : One ownership counter per player (ids 1..NUM_PLAYERS) with a
//             common clear, increment-by-id and combinational read-by-id.
//  Revision : 1.0 - initial release
// ============================================================================
module score_counter_bank
  import score_pkg::*;
#(
  parameter int NUM_PLAYERS = 2,
  parameter int CNT_W       = 4,
  parameter int PID_W       = pid_width(NUM_PLAYERS)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             inc_en_i,
  input  logic [PID_W-1:0] inc_id_i,
  input  logic [PID_W-1:0] rd_id_i,
  output logic [CNT_W-1:0] rd_count_o
);

  // Slot g-1 holds the count of player g
  logic [CNT_W-1:0] cnt_q [NUM_PLAYERS];

  for (genvar g = 1; g <= NUM_PLAYERS; g++) begin : g_cnt
    // Per-player counter: cleared at scan start, bumped when its id is scanned
    always_ff @(posedge clk_i) begin
      if (rst_i || clr_i) begin
        cnt_q[g-1] <= '0;
      end else if (inc_en_i && (int'(inc_id_i) == g)) begin
        cnt_q[g-1] <= cnt_q[g-1] + CNT_W'(1);
      end
    end
  end

  // Read mux; ids outside 1..NUM_PLAYERS read as zero
  always_comb begin
    rd_count_o = '0;
    for (int p = 1; p <= NUM_PLAYERS; p++) begin
      if (int'(rd_id_i) == p) begin
        rd_count_o = cnt_q[p-1];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/score_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : score_arbiter
//  Purpose  : End-of-game scorer. Snapshots the board on Start, counts cell
//             ownership one cell per cycle, then compares the players one per
//             cycle and reports winner / tie / winning count with a Done pulse.
//  Options  : SCORE_MARGIN_EN - track second-best and drive margin_o
//  Revision : 1.0 - initial release
// ============================================================================
module score_arbiter
  import score_pkg::*;
#(
  parameter int NUM_CELLS   = 10,
  parameter int NUM_PLAYERS = 2,
  parameter int PID_W       = pid_width(NUM_PLAYERS),
  parameter int CNT_W       = cnt_width(NUM_CELLS)
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       start_i,
  input  logic [NUM_CELLS*PID_W-1:0] board_i,
  output logic                       busy_o,
  output logic                       done_o,
  output logic [PID_W-1:0]           winner_o,
  output logic                       tie_o,
  output logic [CNT_W-1:0]           win_count_o
`ifdef SCORE_MARGIN_EN
  ,output logic [CNT_W-1:0]          margin_o
`endif
);

  state_t                     state_q, state_d;
  logic [NUM_CELLS*PID_W-1:0] snap_q, snap_d;
  logic [CNT_W-1:0]           idx_q, idx_d;
  logic [PID_W-1:0]           pid_q, pid_d;

  // Running comparator state
  logic [CNT_W-1:0]           best_q, best_d;
  logic [PID_W-1:0]           best_id_q, best_id_d;
  logic                       run_tie_q, run_tie_d;

  // Result registers, held between Done pulses
  logic [PID_W-1:0]           winner_q, winner_d;
  logic                       tie_out_q, tie_out_d;
  logic [CNT_W-1:0]           win_count_q, win_count_d;

`ifdef SCORE_MARGIN_EN
  logic [CNT_W-1:0]           second_q, second_d;
  logic [CNT_W-1:0]           margin_q, margin_d;
`endif

  logic                       w_clr;
  logic                       w_inc_en;
  logic [PID_W-1:0]           w_owner;
  logic [CNT_W-1:0]           w_rd_count;

  // Owner code of the cell under the scan pointer, taken from the snapshot
  assign w_owner = snap_q[int'(idx_q)*PID_W +: PID_W];

  score_counter_bank #(
    .NUM_PLAYERS (NUM_PLAYERS),
    .CNT_W       (CNT_W),
    .PID_W       (PID_W)
  ) u_bank (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .clr_i      (w_clr),
    .inc_en_i   (w_inc_en),
    .inc_id_i   (w_owner),
    .rd_id_i    (pid_q),
    .rd_count_o (w_rd_count)
  );

  // Next-state, scan/compare datapath and result capture
  always_comb begin
    state_d     = state_q;
    snap_d      = snap_q;
    idx_d       = idx_q;
    pid_d       = pid_q;
    best_d      = best_q;
    best_id_d   = best_id_q;
    run_tie_d   = run_tie_q;
    winner_d    = winner_q;
    tie_out_d   = tie_out_q;
    win_count_d = win_count_q;
`ifdef SCORE_MARGIN_EN
    second_d    = second_q;
    margin_d    = margin_q;
`endif
    w_clr       = 1'b0;
    w_inc_en    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          snap_d    = board_i;
          w_clr     = 1'b1;
          idx_d     = '0;
          best_d    = '0;
          best_id_d = '0;
          run_tie_d = 1'b0;
`ifdef SCORE_MARGIN_EN
          second_d  = '0;
`endif
          state_d   = ST_SCAN;
        end
      end

      ST_SCAN: begin
        // Empty cells and codes above NUM_PLAYERS are not counted
        w_inc_en = (int'(w_owner) != OWNER_EMPTY) && (int'(w_owner) <= NUM_PLAYERS);
        if (int'(idx_q) == NUM_CELLS - 1) begin
          pid_d   = PID_W'(1);
          state_d = ST_CMP;
        end else begin
          idx_d   = idx_q + CNT_W'(1);
        end
      end

      ST_CMP: begin
        if (w_rd_count > best_q) begin
`ifdef SCORE_MARGIN_EN
          second_d  = best_q;
`endif
          best_d    = w_rd_count;
          best_id_d = pid_q;
          run_tie_d = 1'b0;
        end else if (w_rd_count == best_q) begin
          run_tie_d = 1'b1;
`ifdef SCORE_MARGIN_EN
          second_d  = best_q;
`endif
        end
`ifdef SCORE_MARGIN_EN
        else if (w_rd_count > second_q) begin
          second_d  = w_rd_count;
        end
`endif
        if (int'(pid_q) == NUM_PLAYERS) begin
          // Capture results on the way into DONE so they are valid with the pulse
          winner_d    = run_tie_d ? '0 : best_id_d;
          tie_out_d   = run_tie_d;
          win_count_d = best_d;
`ifdef SCORE_MARGIN_EN
          margin_d    = run_tie_d ? '0 : (best_d - second_d);
`endif
          state_d     = ST_DONE;
        end else begin
          pid_d       = pid_q + PID_W'(1);
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      snap_q      <= '0;
      idx_q       <= '0;
      pid_q       <= '0;
      best_q      <= '0;
      best_id_q   <= '0;
      run_tie_q   <= 1'b0;
      winner_q    <= '0;
      tie_out_q   <= 1'b0;
      win_count_q <= '0;
`ifdef SCORE_MARGIN_EN
      second_q    <= '0;
      margin_q    <= '0;
`endif
    end else begin
      state_q     <= state_d;
      snap_q      <= snap_d;
      idx_q       <= idx_d;
      pid_q       <= pid_d;
      best_q      <= best_d;
      best_id_q   <= best_id_d;
      run_tie_q   <= run_tie_d;
      winner_q    <= winner_d;
      tie_out_q   <= tie_out_d;
      win_count_q <= win_count_d;
`ifdef SCORE_MARGIN_EN
      second_q    <= second_d;
      margin_q    <= margin_d;
`endif
    end
  end

  assign busy_o      = (state_q != ST_IDLE);
  assign done_o      = (state_q == ST_DONE);
  assign winner_o    = winner_q;
  assign tie_o       = tie_out_q;
  assign win_count_o = win_count_q;
`ifdef SCORE_MARGIN_EN
  assign margin_o    = margin_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_score_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_score_arbiter
//  Purpose  : Directed self-checking bench for score_arbiter: a default
//             (10 cells, 2 players) instance and a 16-cell, 3-player instance.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_score_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        start = 1'b0;
  logic [19:0] board = '0;
  logic        busy, done, tie;
  logic [1:0]  winner;
  logic [3:0]  wc;

  logic        start3 = 1'b0;
  logic [31:0] board3 = '0;
  logic        busy3, done3, tie3;
  logic [1:0]  winner3;
  logic [4:0]  wc3;

`ifdef SCORE_MARGIN_EN
  logic [3:0]  margin;
  logic [4:0]  margin3;
`endif

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  score_arbiter dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .start_i     (start),
    .board_i     (board),
    .busy_o      (busy),
    .done_o      (done),
    .winner_o    (winner),
    .tie_o       (tie),
    .win_count_o (wc)
`ifdef SCORE_MARGIN_EN
    ,.margin_o   (margin)
`endif
  );

  score_arbiter #(.NUM_CELLS(16), .NUM_PLAYERS(3)) dut3 (
    .clk_i       (clk),
    .rst_i       (rst),
    .start_i     (start3),
    .board_i     (board3),
    .busy_o      (busy3),
    .done_o      (done3),
    .winner_o    (winner3),
    .tie_o       (tie3),
    .win_count_o (wc3)
`ifdef SCORE_MARGIN_EN
    ,.margin_o   (margin3)
`endif
  );

  function automatic logic [19:0] pack10(input int c [10]);
    logic [19:0] r;
    r = '0;
    for (int i = 0; i < 10; i++) r[i*2 +: 2] = 2'(c[i]);
    return r;
  endfunction

  function automatic logic [31:0] pack16(input int c [16]);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) r[i*2 +: 2] = 2'(c[i]);
    return r;
  endfunction

  // Advance to 1 time unit after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Pulse start for one sampling edge, then count cycles until Done (-1 on timeout)
  task automatic run_scan(input bit use3, input int limit, output int lat, output bit busy_c1);
    step();
    if (use3) start3 = 1'b1; else start = 1'b1;
    step();
    start  = 1'b0;
    start3 = 1'b0;
    busy_c1 = use3 ? busy3 : busy;
    lat = -1;
    for (int k = 1; k <= limit; k++) begin
      if ((use3 ? done3 : done) === 1'b1) begin
        lat = k;
        break;
      end
      step();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step();
    n_total++; if (busy !== 1'b0)   $display("FAIL reset_busy: got %0d expected 0", busy);     else n_pass++;
    n_total++; if (done !== 1'b0)   $display("FAIL reset_done: got %0d expected 0", done);     else n_pass++;
    n_total++; if (winner !== 2'd0) $display("FAIL reset_winner: got %0d expected 0", winner); else n_pass++;
    n_total++; if (tie !== 1'b0)    $display("FAIL reset_tie: got %0d expected 0", tie);       else n_pass++;
    n_total++; if (wc !== 4'd0)     $display("FAIL reset_wc: got %0d expected 0", wc);         else n_pass++;
    n_total++; if (busy3 !== 1'b0)  $display("FAIL reset_busy3: got %0d expected 0", busy3);   else n_pass++;
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int  cells [10] = '{1, 2, 1, 1, 0, 2, 1, 0, 0, 2};
    int  lat;
    bit  b1;
    board = pack10(cells);
    run_scan(1'b0, 40, lat, b1);
    n_total++; if (b1 !== 1'b1)     $display("FAIL basic_busy: got %0d expected 1", b1);       else n_pass++;
    n_total++; if (lat != 13)       $display("FAIL basic_latency: got %0d expected 13", lat);  else n_pass++;
    n_total++; if (winner !== 2'd1) $display("FAIL basic_winner: got %0d expected 1", winner); else n_pass++;
    n_total++; if (tie !== 1'b0)    $display("FAIL basic_tie: got %0d expected 0", tie);       else n_pass++;
    n_total++; if (wc !== 4'd4)     $display("FAIL basic_wc: got %0d expected 4", wc);         else n_pass++;
`ifdef SCORE_MARGIN_EN
    n_total++; if (margin !== 4'd1) $display("FAIL basic_margin: got %0d expected 1", margin); else n_pass++;
`endif
    step();
    n_total++; if (done !== 1'b0)   $display("FAIL basic_done_pulse: got %0d expected 0", done);  else n_pass++;
    n_total++; if (winner !== 2'd1) $display("FAIL basic_hold: got %0d expected 1", winner);      else n_pass++;
  endtask

  task automatic test_empty();
    int lat;
    bit b1;
    board = '0;
    run_scan(1'b0, 40, lat, b1);
    n_total++; if (lat != 13)       $display("FAIL empty_latency: got %0d expected 13", lat);  else n_pass++;
    n_total++; if (winner !== 2'd0) $display("FAIL empty_winner: got %0d expected 0", winner); else n_pass++;
    n_total++; if (tie !== 1'b1)    $display("FAIL empty_tie: got %0d expected 1", tie);       else n_pass++;
    n_total++; if (wc !== 4'd0)     $display("FAIL empty_wc: got %0d expected 0", wc);         else n_pass++;
`ifdef SCORE_MARGIN_EN
    n_total++; if (margin !== 4'd0) $display("FAIL empty_margin: got %0d expected 0", margin); else n_pass++;
`endif
  endtask

  task automatic test_three_players();
    int cells_tie [16] = '{1, 2, 3, 1, 2, 3, 1, 2, 3, 1, 2, 3, 1, 2, 0, 0};
    int cells_win [16] = '{3, 3, 3, 3, 3, 3, 2, 2, 2, 1, 1, 0, 0, 0, 0, 0};
    int lat;
    bit b1;
    board3 = pack16(cells_tie);
    run_scan(1'b1, 60, lat, b1);
    n_total++; if (lat != 20)        $display("FAIL p3tie_latency: got %0d expected 20", lat);  else n_pass++;
    n_total++; if (tie3 !== 1'b1)    $display("FAIL p3tie_tie: got %0d expected 1", tie3);      else n_pass++;
    n_total++; if (winner3 !== 2'd0) $display("FAIL p3tie_winner: got %0d expected 0", winner3); else n_pass++;
    n_total++; if (wc3 !== 5'd5)     $display("FAIL p3tie_wc: got %0d expected 5", wc3);        else n_pass++;
    board3 = pack16(cells_win);
    run_scan(1'b1, 60, lat, b1);
    n_total++; if (winner3 !== 2'd3) $display("FAIL p3win_winner: got %0d expected 3", winner3); else n_pass++;
    n_total++; if (tie3 !== 1'b0)    $display("FAIL p3win_tie: got %0d expected 0", tie3);      else n_pass++;
    n_total++; if (wc3 !== 5'd6)     $display("FAIL p3win_wc: got %0d expected 6", wc3);        else n_pass++;
`ifdef SCORE_MARGIN_EN
    n_total++; if (margin3 !== 5'd3) $display("FAIL p3win_margin: got %0d expected 3", margin3); else n_pass++;
`endif
  endtask

  task automatic test_midscan_start();
    int cells [10] = '{1, 2, 1, 1, 0, 2, 1, 0, 0, 2};
    int n_done = 0;
    int first  = -1;
    board = pack10(cells);
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      if (done === 1'b1) begin
        n_done++;
        if (first < 0) first = k;
      end
      if (k == 5) begin
        start = 1'b1;
        board = {10{2'd2}};
      end
      if (k == 6) start = 1'b0;
      step();
    end
    n_total++; if (n_done != 1)     $display("FAIL mid_done_count: got %0d expected 1", n_done); else n_pass++;
    n_total++; if (first != 13)     $display("FAIL mid_latency: got %0d expected 13", first);    else n_pass++;
    n_total++; if (winner !== 2'd1) $display("FAIL mid_winner: got %0d expected 1", winner);     else n_pass++;
    n_total++; if (wc !== 4'd4)     $display("FAIL mid_wc: got %0d expected 4", wc);             else n_pass++;
  endtask

  task automatic test_reset_midscan();
    int cells [10] = '{1, 2, 1, 1, 0, 2, 1, 0, 0, 2};
    int n_done = 0;
    int lat;
    bit b1;
    board = {10{2'd2}};
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      if (done === 1'b1) n_done++;
      if (k < 5) step();
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_total++; if (busy !== 1'b0)   $display("FAIL rstmid_busy: got %0d expected 0", busy);     else n_pass++;
    n_total++; if (winner !== 2'd0) $display("FAIL rstmid_winner: got %0d expected 0", winner); else n_pass++;
    n_total++; if (wc !== 4'd0)     $display("FAIL rstmid_wc: got %0d expected 0", wc);         else n_pass++;
    for (int k = 0; k < 20; k++) begin
      if (done === 1'b1) n_done++;
      step();
    end
    n_total++; if (n_done != 0)     $display("FAIL rstmid_no_done: got %0d expected 0", n_done); else n_pass++;
    board = pack10(cells);
    run_scan(1'b0, 40, lat, b1);
    n_total++; if (lat != 13)       $display("FAIL rstmid_latency: got %0d expected 13", lat);  else n_pass++;
    n_total++; if (winner !== 2'd1) $display("FAIL rstmid_rerun_winner: got %0d expected 1", winner); else n_pass++;
    n_total++; if (wc !== 4'd4)     $display("FAIL rstmid_rerun_wc: got %0d expected 4", wc);   else n_pass++;
  endtask

  // Code 3 cells are ignored (p1=1, p2=2); Start held high re-arms in the IDLE
  // cycle after each Done, so each scan is sampled 14 cycles after the previous
  task automatic test_back_to_back();
    int cells [10] = '{3, 3, 3, 3, 2, 2, 1, 0, 3, 0};
    int n_done = 0;
    int d0 = -1;
    int d1 = -1;
    int d2 = -1;
    bit drained = 1'b0;
    board = pack10(cells);
    step();
    start = 1'b1;
    step();
    for (int k = 1; k <= 45; k++) begin
      if (done === 1'b1) begin
        if (n_done == 0) d0 = k;
        else if (n_done == 1) d1 = k;
        else if (n_done == 2) d2 = k;
        n_done++;
      end
      step();
    end
    start = 1'b0;
    n_total++; if (n_done != 3)     $display("FAIL b2b_count: got %0d expected 3", n_done); else n_pass++;
    n_total++; if (d0 != 13)        $display("FAIL b2b_first: got %0d expected 13", d0);    else n_pass++;
    n_total++; if (d1 != 27)        $display("FAIL b2b_second: got %0d expected 27", d1);   else n_pass++;
    n_total++; if (d2 != 41)        $display("FAIL b2b_third: got %0d expected 41", d2);    else n_pass++;
    n_total++; if (winner !== 2'd2) $display("FAIL b2b_winner: got %0d expected 2", winner); else n_pass++;
    n_total++; if (wc !== 4'd2)     $display("FAIL b2b_wc: got %0d expected 2", wc);         else n_pass++;
`ifdef SCORE_MARGIN_EN
    n_total++; if (margin !== 4'd1) $display("FAIL b2b_margin: got %0d expected 1", margin); else n_pass++;
`endif
    for (int k = 0; k < 30; k++) begin
      if (busy === 1'b0) begin
        drained = 1'b1;
        break;
      end
      step();
    end
    n_total++; if (drained !== 1'b1) $display("FAIL b2b_drain: got busy %0d expected 0", busy); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_empty();
    test_three_players();
    test_midscan_start();
    test_reset_midscan();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
